// File: rtl/cfg_arb_pkg.sv
// Shared types and helpers for the configuration-channel arbiter.
// Contents: FSM state encoding, default cfg word width, index-width helper.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned CFG_W_DEFAULT = 64;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
// Ports:
//   req    - per-requester request vector
//   ptr    - highest-priority index this cycle (must be < N)
//   any    - at least one request asserted
//   idx    - index of the winner (0 when none)
//   onehot - one-hot winner vector (0 when none)
module rr_pick
    import cfg_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic                  any,
    output logic [idx_w(N)-1:0]   idx,
    output logic [N-1:0]          onehot
);

    localparam int unsigned IW = idx_w(N);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk offsets 0..N-1 from ptr; lowest offset that is requesting wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_sum  = (IW+1)'(ptr) + (IW+1)'(i);
            w_cand = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
        if (any) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/cfg_arbiter.sv
// Round-robin arbiter sharing one downstream cfg channel between N requesters.
// One configuration is outstanding at a time: accept, issue downstream,
// wait for run completion, then pulse done back to the winner.
// Optional macro CFG_ARBITER_TIMEOUT_EN adds a RUN watchdog (TIMEOUT_CYC cycles).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   s_req_data      - requester i word at [i*B +: B]
//   s_req_valid     - per-requester request valid
//   s_req_ready     - one-hot accept strobe (combinational, IDLE only)
//   s_req_done      - one-hot one-cycle completion pulse
//   m_cfg_data      - latched cfg word
//   m_cfg_valid     - downstream valid (ISSUE state)
//   m_cfg_ready     - downstream ready
//   m_cfg_done      - downstream run complete
//   busy            - not IDLE
//   grant_id        - index of current or last grant
//   timeout_err     - one-cycle watchdog abort pulse
module cfg_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned B           = CFG_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*B-1:0]        s_req_data,
    input  logic [N-1:0]          s_req_valid,
    output logic [N-1:0]          s_req_ready,
    output logic [N-1:0]          s_req_done,
    output logic [B-1:0]          m_cfg_data,
    output logic                  m_cfg_valid,
    input  logic                  m_cfg_ready,
    input  logic                  m_cfg_done,
    output logic                  busy,
    output logic [idx_w(N)-1:0]   grant_id,
    output logic                  timeout_err
);

    localparam int unsigned IW = idx_w(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant_id;
    logic [B-1:0]  r_cfg_data;

    logic          w_any;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_onehot;
    logic          w_wdog_exp;
    logic [IW:0]   w_ptr_inc;
    logic [IW-1:0] w_ptr_nxt;

    rr_pick #(.N(N)) u_pick (
        .req    (s_req_valid),
        .ptr    (r_rr_ptr),
        .any    (w_any),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; m_cfg_done only matters in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any)                      w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (m_cfg_ready)                w_state_nxt = ST_RUN;
            ST_RUN:   if (m_cfg_done || w_wdog_exp)   w_state_nxt = ST_DONE;
            ST_DONE:                                  w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from state; reset drops these asynchronously via r_state.
    always_comb begin
        s_req_ready = '0;
        s_req_done  = '0;
        m_cfg_valid = 1'b0;
        timeout_err = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  s_req_ready = w_onehot;
            ST_ISSUE: m_cfg_valid = 1'b1;
            ST_RUN:   timeout_err = w_wdog_exp && !m_cfg_done;
            ST_DONE:  s_req_done  = N'(1) << r_grant_id;
            default:  ;
        endcase
    end

    assign m_cfg_data = r_cfg_data;
    assign grant_id   = r_grant_id;

    // Pointer advances past the grant that just completed.
    assign w_ptr_inc = (IW+1)'(r_grant_id) + (IW+1)'(1);
    assign w_ptr_nxt = (w_ptr_inc >= (IW+1)'(N)) ? '0 : IW'(w_ptr_inc);

    // Grant capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_cfg_data <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_cfg_data <= s_req_data[32'(w_idx) * B +: B];
                r_grant_id <= w_idx;
            end
            if (r_state == ST_DONE) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef CFG_ARBITER_TIMEOUT_EN
    logic [31:0] r_wdog;

    // Watchdog: zero on entry to RUN, counts each RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == ST_ISSUE && m_cfg_ready) begin
            r_wdog <= '0;
        end else if (r_state == ST_RUN) begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    assign w_wdog_exp = (r_state == ST_RUN) && (r_wdog == 32'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;

    assign w_wdog_exp       = 1'b0;
    assign w_unused_timeout = ^32'(TIMEOUT_CYC);
`endif

endmodule
